lfsr_range_sampler: RTL and testbench
=====================================

Name: lfsr_range_sampler

Overview:
- Consumer stage directly downstream of the 19-bit LFSR.
- Takes raw 19-bit pseudo-random words and turns them into uniformly distributed values in [0, range) by mask-and-reject sampling.
- Emits each result on a valid/ready output and counts rejected words for statistics.

Parameters:
WIDTH, 19, width of random input word, range and output value
CNT_W, 16, width of saturating reject counter

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
rnd_i  input  WIDTH  random word from LFSR
rnd_v_i  input  1  rnd_i valid
rnd_yumi_o  output  1  word consumed this cycle (combinational)
range_i  input  WIDTH  new exclusive upper bound
range_v_i  input  1  load range_i this cycle
out_o  output  WIDTH  sampled value, registered
out_v_o  output  1  out_o valid, registered
out_ready_i  input  1  downstream accepts out_o
reject_cnt_o  output  CNT_W  saturating count of rejected words

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high on rst.
- Reset values: state=IDLE, range_r=0, mask_r=0, out_o=0, out_v_o=0, reject_cnt_o=0, rnd_yumi_o=0.
- States: IDLE (no usable range), SAMPLE (drawing words), HOLD (result presented).
- Range load has top priority, legal in any state. When range_v_i=1:
  - range_r<=range_i and mask_r<=smear(range_i-1). smear sets all bits at and below the MSB, so mask is the smallest 2^k-1 that is >= range-1.
  - range_i=1 gives mask 0. range_i=0 gives mask 0 and next state IDLE; otherwise next state SAMPLE.
  - out_v_o<=0 next cycle. Any held result is discarded, unless out_ready_i=1 in that same cycle, in which case it counts as transferred.
  - reject_cnt_o is not cleared.
- rnd_yumi_o = (state==SAMPLE) & rnd_v_i & ~range_v_i. No consumption in IDLE or HOLD.
- SAMPLE, on yumi, with cand = rnd_i & mask_r:
  - If cand < range_r: out_o<=cand, out_v_o<=1, go to HOLD. Latency is 1 cycle from consumed word to out_v_o.
  - Otherwise: reject_cnt_o<=reject_cnt_o+1, saturating at 2^CNT_W-1; stay in SAMPLE.
- HOLD:
  - out_o and out_v_o stay stable until out_ready_i=1.
  - On out_ready_i=1 (and no range_v_i): out_v_o<=0, go to SAMPLE.
  - Maximum throughput is one result per 2 cycles.
- Comparisons are unsigned, WIDTH bits. The mask guarantees acceptance probability >0.5 per word.
- IDLE: out_v_o=0; only range_v_i leaves it.
- Reset mid-operation: held output and range are lost; return to IDLE with all reset values.

Test Plan:
- Assert rst 2 cycles with rnd_v_i=1 and range_v_i=0 -> out_v_o=0, out_o=0, reject_cnt_o=0, rnd_yumi_o=0 throughout and after.
- Load range 10 (mask 0xF), then rnd_i=0x00003 -> yumi=1 that cycle; next cycle out_v_o=1, out_o=3. Hold out_ready_i=0 for 4 cycles -> out_o stays 3 and yumi=0 with rnd_v_i=1. Pulse ready -> out_v_o=0 next cycle.
- Range 10, feed 0x0000C then 0x7FFF5 -> first word rejected (cand 12), reject_cnt_o=1; second gives out_o=5.
- Load range 1, feed 0x7FFFF -> out_o=0, reject_cnt_o unchanged. Load range 0x7FFFF, feed 0x7FFFF -> rejected; feed 0x7FFFE -> out_o=0x7FFFE.
- In HOLD with out_o=5, assert range_v_i with range_i=3 and out_ready_i=0 -> out_v_o=0 next cycle, state SAMPLE, mask 0x3. Same cycle rnd_v_i=1 -> yumi=0.
- Load range 0 -> IDLE, yumi stays 0. Force 2^16+3 rejections (range 9, cand 15) -> reject_cnt_o saturates at 0xFFFF.

Source files
------------

// File: rtl/lfsr_range_sampler.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_range_sampler
// Function : Mask-and-reject sampler that turns raw LFSR words into uniformly
//            distributed values in [0, range), with a saturating reject count.
// Revision : 1.0
// ============================================================================
module lfsr_range_sampler #(
    parameter int WIDTH = 19,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rnd_i,
    input  logic             rnd_v_i,
    output logic             rnd_yumi_o,
    input  logic [WIDTH-1:0] range_i,
    input  logic             range_v_i,
    output logic [WIDTH-1:0] out_o,
    output logic             out_v_o,
    input  logic             out_ready_i,
    output logic [CNT_W-1:0] reject_cnt_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] range_q, range_d;
    logic [WIDTH-1:0] mask_q,  mask_d;
    logic [WIDTH-1:0] out_q,   out_d;
    logic             out_v_q, out_v_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] cand;
    logic             yumi;

    // Propagates the highest set bit downward, giving the smallest 2^k-1 >= x.
    function automatic logic [WIDTH-1:0] smear(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        r = x;
        for (int i = 1; i < WIDTH; i++) begin
            r = r | (r >> 1);
        end
        return r;
    endfunction

    assign yumi = (state_q == SAMPLE) & rnd_v_i & ~range_v_i;
    assign cand = rnd_i & mask_q;

    always_comb begin
        state_d = state_q;
        range_d = range_q;
        mask_d  = mask_q;
        out_d   = out_q;
        out_v_d = out_v_q;
        cnt_d   = cnt_q;

        if (range_v_i) begin
            // A new range always wins; any held result is dropped.
            range_d = range_i;
            mask_d  = (range_i == '0) ? '0 : smear(range_i - ONE_W);
            out_v_d = 1'b0;
            state_d = (range_i == '0) ? IDLE : SAMPLE;
        end else begin
            case (state_q)
                SAMPLE: begin
                    if (yumi) begin
                        if (cand < range_q) begin
                            out_d   = cand;
                            out_v_d = 1'b1;
                            state_d = HOLD;
                        end else if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + ONE_C;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready_i) begin
                        out_v_d = 1'b0;
                        state_d = SAMPLE;
                    end
                end
                default: begin
                    out_v_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            range_q <= '0;
            mask_q  <= '0;
            out_q   <= '0;
            out_v_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            range_q <= range_d;
            mask_q  <= mask_d;
            out_q   <= out_d;
            out_v_q <= out_v_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rnd_yumi_o   = yumi;
    assign out_o        = out_q;
    assign out_v_o      = out_v_q;
    assign reject_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_range_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_range_sampler
// Function : Vector table, directed corner sequences and a randomized run
//            against a transaction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_lfsr_range_sampler;

    logic        clk;
    logic        rst;
    logic [18:0] rnd_i;
    logic        rnd_v_i;
    logic        rnd_yumi_o;
    logic [18:0] range_i;
    logic        range_v_i;
    logic [18:0] out_o;
    logic        out_v_o;
    logic        out_ready_i;
    logic [15:0] reject_cnt_o;

    lfsr_range_sampler #(.WIDTH(19), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .rnd_i        (rnd_i),
        .rnd_v_i      (rnd_v_i),
        .rnd_yumi_o   (rnd_yumi_o),
        .range_i      (range_i),
        .range_v_i    (range_v_i),
        .out_o        (out_o),
        .out_v_o      (out_v_o),
        .out_ready_i  (out_ready_i),
        .reject_cnt_o (reject_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] rng;
        logic [18:0] rnd;
        bit          acc;
        logic [18:0] exp_out;
    } vec_t;

    vec_t        vecs[11];
    int          n_pass;
    int          n_total;
    int unsigned exp_rej;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // Smallest 2^k-1 covering range-1, computed by repeated doubling.
    function automatic int unsigned mask_of(input int unsigned r);
        int unsigned m;
        m = 0;
        if (r <= 1) return 0;
        while (m < r - 1) m = m * 2 + 1;
        return m;
    endfunction

    function automatic int unsigned sat_inc(input int unsigned c);
        return (c >= 32'hFFFF) ? 32'hFFFF : c + 1;
    endfunction

    task automatic load_range(input logic [18:0] r);
        range_i     = r;
        range_v_i   = 1'b1;
        out_ready_i = 1'b1;
        rnd_v_i     = 1'b1;
        #1;
        chk("yumi_during_load", rnd_yumi_o, 0);
        tick;
        range_v_i   = 1'b0;
        out_ready_i = 1'b0;
        rnd_v_i     = 1'b0;
    endtask

    task automatic feed(input logic [18:0] w);
        rnd_i   = w;
        rnd_v_i = 1'b1;
        #1;
        chk("yumi_feed", rnd_yumi_o, 1);
        tick;
        rnd_v_i = 1'b0;
    endtask

    // Reference model state for the randomized run
    int unsigned m_rng, m_mask, m_out, m_cnt, m_cand;
    bit          m_has, m_hold, m_yumi;

    initial begin
        n_pass  = 0;
        n_total = 0;
        exp_rej = 0;
        vecs[0]  = '{19'd10,      19'h00003, 1'b1, 19'd3};
        vecs[1]  = '{19'd10,      19'h0000C, 1'b0, 19'd0};
        vecs[2]  = '{19'd10,      19'h7FFF5, 1'b1, 19'd5};
        vecs[3]  = '{19'd1,       19'h7FFFF, 1'b1, 19'd0};
        vecs[4]  = '{19'h7FFFF,   19'h7FFFF, 1'b0, 19'd0};
        vecs[5]  = '{19'h7FFFF,   19'h7FFFE, 1'b1, 19'h7FFFE};
        vecs[6]  = '{19'd3,       19'h00006, 1'b1, 19'd2};
        vecs[7]  = '{19'd9,       19'h0001F, 1'b0, 19'd0};
        vecs[8]  = '{19'd9,       19'h00008, 1'b1, 19'd8};
        vecs[9]  = '{19'h40000,   19'h7FFFF, 1'b1, 19'h3FFFF};
        vecs[10] = '{19'h40001,   19'h7FFFF, 1'b0, 19'd0};

        rst = 1'b1; rnd_i = 19'h12345; rnd_v_i = 1'b1; range_i = '0;
        range_v_i = 1'b0; out_ready_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick;
            chk("rst_out_v", out_v_o, 0);
            chk("rst_out", out_o, 0);
            chk("rst_cnt", reject_cnt_o, 0);
            chk("rst_yumi", rnd_yumi_o, 0);
        end
        rst = 1'b0;
        tick;
        chk("post_rst_out_v", out_v_o, 0);
        chk("post_rst_yumi", rnd_yumi_o, 0);
        rnd_v_i = 1'b0;

        for (int i = 0; i < 11; i++) begin
            load_range(vecs[i].rng);
            feed(vecs[i].rnd);
            if (!vecs[i].acc) exp_rej = sat_inc(exp_rej);
            chk("vec_out_v", out_v_o, vecs[i].acc);
            if (vecs[i].acc) chk("vec_out", out_o, vecs[i].exp_out);
            chk("vec_cnt", reject_cnt_o, exp_rej);
        end

        // Held result stays put while downstream stalls
        load_range(19'd10);
        feed(19'h00003);
        rnd_v_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk("hold_yumi", rnd_yumi_o, 0);
            tick;
            chk("hold_out_v", out_v_o, 1);
            chk("hold_out", out_o, 3);
        end
        rnd_v_i = 1'b0; out_ready_i = 1'b1;
        tick;
        out_ready_i = 1'b0;
        chk("ready_out_v", out_v_o, 0);
        rnd_v_i = 1'b1;
        #1;
        chk("ready_back_sample", rnd_yumi_o, 1);
        rnd_v_i = 1'b0;

        // Range reload while holding discards the result and narrows the mask
        feed(19'h00005);
        chk("pre_reload_out", out_o, 5);
        range_i = 19'd3; range_v_i = 1'b1; rnd_v_i = 1'b1; out_ready_i = 1'b0;
        #1;
        chk("reload_yumi", rnd_yumi_o, 0);
        tick;
        range_v_i = 1'b0; rnd_v_i = 1'b0;
        chk("reload_out_v", out_v_o, 0);
        feed(19'h00007);
        exp_rej = sat_inc(exp_rej);
        chk("reload_rej_out_v", out_v_o, 0);
        chk("reload_rej_cnt", reject_cnt_o, exp_rej);
        feed(19'h00006);
        chk("reload_acc_out_v", out_v_o, 1);
        chk("reload_acc_out", out_o, 2);

        // Range zero parks the block
        load_range(19'd0);
        rnd_v_i = 1'b1;
        #1;
        chk("idle_yumi", rnd_yumi_o, 0);
        tick;
        chk("idle_out_v", out_v_o, 0);
        chk("idle_yumi2", rnd_yumi_o, 0);
        rnd_v_i = 1'b0;

        // Drive the reject counter into saturation
        load_range(19'd9);
        rnd_i = 19'h0001F; rnd_v_i = 1'b1;
        repeat (65539) @(posedge clk);
        #1;
        for (int c = 0; c < 65539; c++) exp_rej = sat_inc(exp_rej);
        chk("sat_cnt", reject_cnt_o, 32'hFFFF);
        chk("sat_cnt_model", reject_cnt_o, exp_rej);
        tick;
        chk("sat_cnt_hold", reject_cnt_o, 32'hFFFF);
        rnd_v_i = 1'b0;

        // Reset mid-operation, then randomized traffic
        load_range(19'd7);
        feed(19'h00002);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst_out_v", out_v_o, 0);
        chk("midrst_out", out_o, 0);
        chk("midrst_cnt", reject_cnt_o, 0);
        m_rng = 0; m_mask = 0; m_out = 0; m_cnt = 0; m_has = 0; m_hold = 0;

        for (int c = 0; c < 3000; c++) begin
            range_v_i   = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       range_i = 19'($urandom_range(0, 3));
                1:       range_i = 19'($urandom);
                default: range_i = 19'($urandom_range(4, 40));
            endcase
            rnd_i       = 19'($urandom);
            rnd_v_i     = ($urandom_range(0, 3) != 0);
            out_ready_i = $urandom_range(0, 1);
            m_yumi = m_has && !m_hold && rnd_v_i && !range_v_i;
            #1;
            chk("rnd_yumi", rnd_yumi_o, m_yumi);
            if (range_v_i) begin
                m_rng  = range_i;
                m_mask = mask_of(range_i);
                m_has  = (range_i != 0);
                m_hold = 0;
            end else if (m_yumi) begin
                m_cand = rnd_i & m_mask;
                if (m_cand < m_rng) begin
                    m_out  = m_cand;
                    m_hold = 1;
                end else begin
                    m_cnt = sat_inc(m_cnt);
                end
            end else if (m_hold && out_ready_i) begin
                m_hold = 0;
            end
            tick;
            chk("rnd_out_v", out_v_o, m_hold);
            chk("rnd_out", out_o, m_out);
            chk("rnd_cnt", reject_cnt_o, m_cnt);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
